// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_ctrl_pkg: shared types and constants for the pipeline hazard controller.
//   fwd_sel_e : operand source select driven onto fwda/fwdb
//   state_e   : front-end control FSM states
//   shadow_t  : register-write summary of the instruction held in EX or MEM
package pipe_ctrl_pkg;

  // EX-stage occupancy of a multiply/divide; legal range 2..4 so the wait
  // counter fits in two bits.
  localparam int MDU_LAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    FWD_REG  = 2'b00,  // register file read
    FWD_EXE  = 2'b01,  // EX-stage ALU result
    FWD_MEM  = 2'b10,  // MEM-stage ALU result
    FWD_LOAD = 2'b11   // MEM-stage load data
  } fwd_sel_e;

  typedef enum logic {
    RUN      = 1'b0,
    MDU_WAIT = 1'b1
  } state_e;

  typedef struct packed {
    logic       wreg;   // writes a GPR
    logic       m2reg;  // is a load
    logic [4:0] rn;     // destination register
  } shadow_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: bundle between the pipeline datapath and the hazard
// controller.
//   ID-stage info  : drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dmdu, dtaken
//   Stage control  : wpcir, dbubble, dflush
//   Forward select : fwda, fwdb
//   Perf counters  : stall_cnt, flush_cnt
// slave modport is the controller side, master the datapath side.
interface pipe_hazard_ctrl_if;
  logic [4:0]  drs;
  logic [4:0]  drt;
  logic        duse_rs;
  logic        duse_rt;
  logic        dwreg;
  logic        dm2reg;
  logic [4:0]  drn;
  logic        dmdu;
  logic        dtaken;
  logic        wpcir;
  logic        dbubble;
  logic        dflush;
  logic [1:0]  fwda;
  logic [1:0]  fwdb;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  modport slave (
    input  drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dmdu, dtaken,
    output wpcir, dbubble, dflush, fwda, fwdb, stall_cnt, flush_cnt
  );

  modport master (
    output drs, drt, duse_rs, duse_rt, dwreg, dm2reg, drn, dmdu, dtaken,
    input  wpcir, dbubble, dflush, fwda, fwdb, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd.sv
// pipe_fwd_unit: combinational forwarding compare for one source operand.
//   src  : ID-stage source register number
//   e_sh : EX-stage shadow, m_sh : MEM-stage shadow
//   sel  : operand select (EX ALU beats MEM; a load still in EX is never
//          forwarded, the load-use stall covers it)
module pipe_fwd_unit
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  shadow_t    e_sh,
  input  shadow_t    m_sh,
  output fwd_sel_e   sel
);

  always_comb begin
    sel = FWD_REG;
    if (e_sh.wreg && !e_sh.m2reg && (e_sh.rn != 5'd0) && (e_sh.rn == src)) begin
      sel = FWD_EXE;
    end else if (m_sh.wreg && (m_sh.rn != 5'd0) && (m_sh.rn == src)) begin
      sel = m_sh.m2reg ? FWD_LOAD : FWD_MEM;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: front-end hazard controller for a 5-stage pipeline.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   hif (slave)  : ID-stage instruction info in; wpcir/dbubble/dflush stage
//                  control, fwda/fwdb operand selects and saturating
//                  stall/flush counters out
// Parameter MDU_LAT (2..4): EX occupancy of a multiply/divide; the front end
// stalls MDU_LAT-1 cycles after the MDU instruction enters EX.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MDU_LAT = MDU_LAT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hif
);

  localparam logic [1:0] CNT_LOAD = 2'(MDU_LAT - 2);

  state_e      state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  shadow_t     e_reg, m_reg;
  logic [15:0] stall_cnt_reg, flush_cnt_reg;
  logic        load_use;
  logic        wpcir, dbubble, dflush;

  // A load in EX whose target is read by the ID instruction; r0 never stalls.
  assign load_use = e_reg.m2reg && (e_reg.rn != 5'd0) &&
                    ((hif.duse_rs && (hif.drs == e_reg.rn)) ||
                     (hif.duse_rt && (hif.drt == e_reg.rn)));

  // State register, shadows and counters.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= RUN;
      cnt_reg       <= 2'd0;
      e_reg         <= '0;
      m_reg         <= '0;
      stall_cnt_reg <= 16'd0;
      flush_cnt_reg <= 16'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      m_reg     <= e_reg;
      e_reg     <= dbubble ? shadow_t'('0) : shadow_t'({hif.dwreg, hif.dm2reg, hif.drn});
      if (!wpcir && (stall_cnt_reg != 16'hFFFF)) begin
        stall_cnt_reg <= stall_cnt_reg + 16'd1;
      end
      if (dflush && (flush_cnt_reg != 16'hFFFF)) begin
        flush_cnt_reg <= flush_cnt_reg + 16'd1;
      end
    end
  end

  // Next state. The MDU instruction itself advances into EX in RUN; the
  // wait then lasts CNT_LOAD+1 = MDU_LAT-1 cycles.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      RUN: begin
        if (hif.dmdu && !load_use) begin
          state_next = MDU_WAIT;
          cnt_next   = CNT_LOAD;
        end
      end
      MDU_WAIT: begin
        if (cnt_reg == 2'd0) begin
          state_next = RUN;
        end else begin
          cnt_next = cnt_reg - 2'd1;
        end
      end
      default: begin
        state_next = RUN;
        cnt_next   = 2'd0;
      end
    endcase
  end

  // Stage control. Reset forces the idle pattern regardless of stale state;
  // any stall suppresses the flush so the branch re-evaluates on re-present.
  always_comb begin
    wpcir   = 1'b1;
    dbubble = 1'b0;
    dflush  = 1'b0;
    if (!reset) begin
      case (state_reg)
        RUN: begin
          if (load_use) begin
            wpcir   = 1'b0;
            dbubble = 1'b1;
          end else begin
            dflush = hif.dtaken;
          end
        end
        MDU_WAIT: begin
          wpcir   = 1'b0;
          dbubble = 1'b1;
        end
        default: begin
          wpcir = 1'b1;
        end
      endcase
    end
  end

  assign hif.wpcir     = wpcir;
  assign hif.dbubble   = dbubble;
  assign hif.dflush    = dflush;
  assign hif.stall_cnt = stall_cnt_reg;
  assign hif.flush_cnt = flush_cnt_reg;

  // One forwarding compare per source operand: index 0 = rs, 1 = rt.
  logic [4:0] fwd_src [2];
  fwd_sel_e   fwd_sel [2];

  assign fwd_src[0] = hif.drs;
  assign fwd_src[1] = hif.drt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      pipe_fwd_unit u_fwd (
        .src  (fwd_src[gi]),
        .e_sh (e_reg),
        .m_sh (m_reg),
        .sel  (fwd_sel[gi])
      );
    end
  endgenerate

  assign hif.fwda = reset ? FWD_REG : fwd_sel[0];
  assign hif.fwdb = reset ? FWD_REG : fwd_sel[1];

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: directed scenarios followed by random
// stimulus, every cycle compared against an instruction-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int LAT = 4;

  logic clock = 1'b0;
  logic reset;
  int   total  = 0;
  int   passed = 0;

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(.MDU_LAT(LAT)) dut (
    .clock (clock),
    .reset (reset),
    .hif   (hif)
  );

  always #5 clock = ~clock;

  // Reference model: what occupies EX and MEM, how many MDU wait cycles are
  // still owed, and the two event counts.
  bit m_ew, m_em, m_mw, m_mm;
  int m_ern, m_mrn;
  int wait_left, scnt, fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic bit model_hazard();
    return m_em && (m_ern != 0) &&
           ((hif.duse_rs && (int'(hif.drs) == m_ern)) ||
            (hif.duse_rt && (int'(hif.drt) == m_ern)));
  endfunction

  function automatic int model_fwd(input int src);
    if (reset) return 0;
    if (m_ew && !m_em && m_ern != 0 && m_ern == src) return 1;
    if (m_mw && m_mrn != 0 && m_mrn == src) return m_mm ? 3 : 2;
    return 0;
  endfunction

  task automatic model_ctrl(output bit w, output bit b, output bit f);
    bit stall;
    stall = !reset && (wait_left > 0 || model_hazard());
    w = !stall;
    b = stall;
    f = !reset && !stall && hif.dtaken;
  endtask

  task automatic model_edge();
    bit w, b, f;
    if (reset) begin
      {m_ew, m_em, m_mw, m_mm} = '0;
      m_ern = 0; m_mrn = 0;
      wait_left = 0; scnt = 0; fcnt = 0;
    end else begin
      model_ctrl(w, b, f);
      if (!w && scnt < 65535) scnt++;
      if (f && fcnt < 65535) fcnt++;
      if (wait_left > 0) wait_left--;
      else if (hif.dmdu && !model_hazard()) wait_left = LAT - 1;
      m_mw = m_ew; m_mm = m_em; m_mrn = m_ern;
      m_ew = b ? 1'b0 : hif.dwreg;
      m_em = b ? 1'b0 : hif.dm2reg;
      m_ern = b ? 0 : int'(hif.drn);
    end
  endtask

  // One clock: optionally compare every output with the model, then advance.
  task automatic cycle(input bit do_chk);
    bit w, b, f;
    #1;
    if (do_chk) begin
      model_ctrl(w, b, f);
      chk("wpcir", 32'(hif.wpcir), 32'(w));
      chk("dbubble", 32'(hif.dbubble), 32'(b));
      chk("dflush", 32'(hif.dflush), 32'(f));
      chk("fwda", 32'(hif.fwda), 32'(model_fwd(int'(hif.drs))));
      chk("fwdb", 32'(hif.fwdb), 32'(model_fwd(int'(hif.drt))));
      chk("stall_cnt", 32'(hif.stall_cnt), 32'(scnt));
      chk("flush_cnt", 32'(hif.flush_cnt), 32'(fcnt));
    end
    @(posedge clock);
    #1;
    model_edge();
  endtask

  task automatic set_in(input int rs, input int rt, input bit urs, input bit urt,
                        input bit wreg, input bit m2reg, input int rn,
                        input bit mdu, input bit taken);
    hif.drs = 5'(rs); hif.drt = 5'(rt);
    hif.duse_rs = urs; hif.duse_rt = urt;
    hif.dwreg = wreg; hif.dm2reg = m2reg; hif.drn = 5'(rn);
    hif.dmdu = mdu; hif.dtaken = taken;
  endtask

  initial begin
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0);
    // Reset with a hazard-looking instruction present must still look idle.
    set_in(5, 5, 1, 1, 1, 1, 5, 1, 1);
    cycle(1);
    cycle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    #1; chk("post_reset_wpcir", 32'(hif.wpcir), 32'd1);
    cycle(1);

    // Load r5 in EX, ID add reads r5: one stall, then MEM load forward.
    set_in(0, 0, 0, 0, 1, 1, 5, 0, 0);
    cycle(1);
    set_in(5, 7, 1, 1, 1, 0, 8, 0, 0);
    #1; chk("lu_wpcir", 32'(hif.wpcir), 32'd0);
    chk("lu_dbubble", 32'(hif.dbubble), 32'd1);
    cycle(1);
    #1; chk("lu_fwda_load", 32'(hif.fwda), 32'd3);
    chk("lu_stall_cnt", 32'(hif.stall_cnt), 32'd1);
    chk("lu_no_restall", 32'(hif.wpcir), 32'd1);
    cycle(1);

    // EX and MEM both write r3: EX wins; r0 in EX never forwards.
    set_in(0, 0, 0, 0, 1, 0, 3, 0, 0);
    cycle(1);
    cycle(1);
    set_in(0, 3, 0, 1, 1, 0, 0, 0, 0);
    #1; chk("fwdb_ex_prio", 32'(hif.fwdb), 32'd1);
    cycle(1);
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 0);
    #1; chk("fwdb_r0", 32'(hif.fwdb), 32'd0);
    cycle(1);

    // Multiply/divide: MDU_LAT-1 stall cycles; dmdu/dtaken ignored meanwhile.
    set_in(1, 2, 1, 1, 0, 0, 0, 1, 0);
    #1; chk("mdu_issue_wpcir", 32'(hif.wpcir), 32'd1);
    cycle(1);
    set_in(1, 2, 1, 1, 0, 0, 0, 1, 1);
    for (int i = 0; i < LAT - 1; i++) begin
      #1; chk("mdu_wait_wpcir", 32'(hif.wpcir), 32'd0);
      chk("mdu_wait_dflush", 32'(hif.dflush), 32'd0);
      cycle(1);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("mdu_done_wpcir", 32'(hif.wpcir), 32'd1);
    chk("mdu_stall_cnt", 32'(hif.stall_cnt), 32'd4);
    cycle(1);

    // Load-use together with a taken branch: stall wins, flush follows.
    set_in(0, 0, 0, 0, 1, 1, 6, 0, 0);
    cycle(1);
    set_in(6, 0, 1, 0, 0, 0, 0, 0, 1);
    #1; chk("lu_br_dflush", 32'(hif.dflush), 32'd0);
    cycle(1);
    #1; chk("br_dflush", 32'(hif.dflush), 32'd1);
    cycle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1; chk("br_flush_cnt", 32'(hif.flush_cnt), 32'd1);
    cycle(1);

    // Reset in the second MDU wait cycle aborts the wait.
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1);
    reset = 1'b1;
    cycle(1);
    reset = 1'b0;
    #1; chk("abort_wpcir", 32'(hif.wpcir), 32'd1);
    chk("abort_stall_cnt", 32'(hif.stall_cnt), 32'd0);
    chk("abort_flush_cnt", 32'(hif.flush_cnt), 32'd0);
    cycle(1);

    // Random traffic over a small register set to force collisions.
    for (int i = 0; i < 300; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 3),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0));
      reset = ($urandom_range(0, 49) == 0);
      cycle(1);
    end

    // Saturation: back-to-back MDU ops stall 3 of every 4 cycles.
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
    cycle(1);
    reset = 1'b0;
    for (int i = 0; i < 87390; i++) cycle(0);
    #1; chk("sat_stall_cnt", 32'(hif.stall_cnt), 32'hFFFF);
    for (int i = 0; i < 8; i++) cycle(1);
    #1; chk("sat_hold", 32'(hif.stall_cnt), 32'hFFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high; ports named clock and reset.
REQ-002 Parameter MDU_LAT, default 4, meaning EX-stage occupancy in cycles of a multiply/divide instruction; legal range 2..4.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 drs, drt  input  5 each  ID-stage source register numbers.
REQ-006 duse_rs, duse_rt  input  1 each  ID instruction actually reads rs / rt.
REQ-007 dwreg, dm2reg  input  1 each  ID instruction writes a GPR / is a load.
REQ-008 drn  input  5  ID-stage destination register number.
REQ-009 dmdu  input  1  ID instruction is multiply/divide; it writes HI/LO only, never a GPR.
REQ-010 dtaken  input  1  branch or jump resolved taken in ID.
REQ-011 wpcir  output  1  PC and IF/ID write enable; 1 = advance.
REQ-012 dbubble  output  1  replace ID/EX controls with a no-op this edge.
REQ-013 dflush  output  1  kill the IF/ID instruction this edge.
REQ-014 fwda, fwdb  output  2 each  operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data.
REQ-015 stall_cnt, flush_cnt  output  16 each  saturating performance counters.

Function
REQ-016 The block SHALL keep E shadow {ewreg, em2reg, ern} and M shadow {mwreg, mm2reg, mrn}; each edge: M <= E, and E <= 0 if dbubble, else {dwreg, dm2reg, drn}.
REQ-017 Load-use hazard: em2reg=1, ern!=0, and (duse_rs and drs==ern or duse_rt and drt==ern).
REQ-018 On a load-use hazard in RUN: wpcir=0, dbubble=1, dflush=0, for exactly one cycle; the following cycle SHALL see no hazard from the same load.
REQ-019 fwda SHALL be 01 if ewreg, !em2reg, ern!=0, ern==drs; else 1x if mwreg, mrn!=0, mrn==drs (11 if mm2reg, else 10); else 00. fwdb SHALL follow the same rule on drt; EX match has priority over MEM.
REQ-020 Register 0 SHALL never forward or stall.
REQ-021 FSM states RUN and MDU_WAIT; reset state RUN.
REQ-022 RUN -> MDU_WAIT when dmdu=1 and no load-use hazard; a 2-bit counter loads MDU_LAT-2.
REQ-023 In MDU_WAIT: wpcir=0, dbubble=1, dflush=0; counter decrements each cycle; when counter==0, return to RUN next edge; total front-end stall = MDU_LAT-1 cycles.
REQ-024 dtaken in RUN with no stall: dflush=1 for one cycle, wpcir=1, dbubble=0.
REQ-025 Simultaneous stall and dtaken: stall SHALL win; dflush=0; dtaken is re-evaluated when the instruction re-presents.
REQ-026 dtaken and dmdu in MDU_WAIT SHALL be ignored.
REQ-027 stall_cnt SHALL increment on every cycle with wpcir=0; flush_cnt SHALL increment on every cycle with dflush=1; both saturate at 16'hFFFF.
REQ-028 wpcir, dbubble, and dflush SHALL be combinational from the current state and inputs; fwda and fwdb SHALL be combinational from the shadows and inputs.

Reset
REQ-029 On reset=1 at a rising edge, state=RUN, counter=0, E and M shadows=0, and stall_cnt=flush_cnt=0.
REQ-030 During and right after reset, outputs SHALL be wpcir=1, dbubble=0, dflush=0, fwda=fwdb=00.
REQ-031 Reset asserted in MDU_WAIT SHALL abort the wait; RUN applies on the next cycle.

Structure
REQ-032 Package pipe_ctrl_pkg SHALL hold the FWD_REG/FWD_EXE/FWD_MEM/FWD_LOAD encodings, the state enum, and the MDU_LAT default.
REQ-033 Forwarding compare SHALL be one combinational sub-module, pipe_fwd_unit, instanced once per operand.
REQ-034 Target size is 120-400 lines of RTL.

Verification
REQ-035 Load r5 in EX; ID add uses rs=5 -> one cycle wpcir=0, dbubble=1; next cycle fwda=11, stall_cnt=1.
REQ-036 EX add writes r3; MEM add writes r3; ID uses rt=3 -> fwdb=01 (EX priority); with rt=0 and ern=0 -> fwdb=00.
REQ-037 dmdu=1 in RUN with MDU_LAT=4 -> wpcir=0 for 3 cycles, then RUN; stall_cnt=3.
REQ-038 Load-use hazard with dtaken=1 -> dflush=0 in the stall cycle; next cycle dflush=1; flush_cnt=1.
REQ-039 Reset pulse in second MDU_WAIT cycle -> next cycle RUN, wpcir=1, counters=0.
REQ-040 Force 65535 stall cycles plus 1 -> stall_cnt holds 16'hFFFF.
